// File: rtl/tick_gen_pkg.sv
// Tick generator shared types: mode encoding, default divisors
// for a 100 MHz clock, and the channel-select width helper.
package tick_gen_pkg;

  typedef enum logic {
    PULSE  = 1'b0,
    SQUARE = 1'b1
  } mode_e;

  localparam int unsigned DIV_2HZ   = 50000000;
  localparam int unsigned DIV_1HZ   = 100000000;
  localparam int unsigned DIV_4HZ   = 25000000;
  localparam int unsigned DIV_400HZ = 250000;

  // channel select width, never below 1 bit
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_bank_if.sv
// Divisor/mode write bus of the tick bank.
// master: cfg_we/cfg_ch/cfg_div/cfg_mode out, cfg_err in.
interface tick_gen_bank_if
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);

  localparam int CH_W = ch_w(NUM_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  mode_e            cfg_mode;
  logic             cfg_err;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_div,
    output cfg_mode,
    input  cfg_err
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_mode,
    output cfg_err
  );

endinterface

// File: rtl/tick_chan.sv
// One tick channel: counter, shadowed divisor/mode, tick and wave.
// Ports: clk, rst, en, clr, wr/wr_div/wr_mode -> tick, wave.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DIV_1HZ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  mode_e            wr_mode,
  output logic             tick,
  output logic             wave
);

  logic [CNT_W-1:0] d_q, d_nx;
  logic [CNT_W-1:0] s_q, s_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  mode_e            sm_q, sm_nx;
  mode_e            m_q, m_nx;
  logic             tick_nx, wave_nx;
  logic             wrap, load;

  // a write in the wrap cycle is forwarded
  assign s_nx  = wr ? wr_div  : s_q;
  assign sm_nx = wr ? wr_mode : sm_q;

  assign wrap = en && (cnt_q >= d_q - CNT_W'(1));
  assign load = clr || wrap || (!en && wr);

  always_comb begin
    d_nx    = d_q;
    m_nx    = m_q;
    cnt_nx  = cnt_q;
    tick_nx = 1'b0;
    wave_nx = wave;
    if (load) begin
      d_nx = s_nx;
      m_nx = sm_nx;
    end
    if (clr) begin
      cnt_nx = '0;
    end else if (wrap) begin
      cnt_nx  = '0;
      tick_nx = 1'b1;
    end else if (en) begin
      cnt_nx = cnt_q + CNT_W'(1);
    end else if (load && cnt_q >= d_nx) begin
      // shrunk divisor while frozen
      cnt_nx = '0;
    end
    if (m_nx == PULSE)
      wave_nx = tick_nx;
    else if (clr || m_nx != m_q)
      wave_nx = 1'b0;
    else if (wrap)
      wave_nx = ~wave;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q   <= DEF_DIV;
      s_q   <= DEF_DIV;
      sm_q  <= PULSE;
      m_q   <= PULSE;
      cnt_q <= '0;
      tick  <= 1'b0;
      wave  <= 1'b0;
    end else begin
      d_q   <= d_nx;
      s_q   <= s_nx;
      sm_q  <= sm_nx;
      m_q   <= m_nx;
      cnt_q <= cnt_nx;
      tick  <= tick_nx;
      wave  <= wave_nx;
    end
  end

endmodule

// File: rtl/tick_gen_bank.sv
// Bank of NUM_CH tick channels with a shared config write bus.
// Ports: clk, rst, ch_en, sync_clr, cfg (slave) -> tick, wave.
module tick_gen_bank
  import tick_gen_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          CNT_W   = 32,
  parameter int unsigned DEF_DIV = DIV_1HZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  tick_gen_bank_if.slave    cfg,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] wave
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam logic [CH_W:0] NUM_V =
    (CH_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] DEF_V =
    CNT_W'(DEF_DIV);

  logic              ch_ok;
  logic              wr_ok;
  logic              err_q;
  logic [NUM_CH-1:0] wr_sel;

  assign ch_ok = {1'b0, cfg.cfg_ch} < NUM_V;
  assign wr_ok = cfg.cfg_we && ch_ok &&
                 (cfg.cfg_div != '0);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (wr_ok && cfg.cfg_ch == CH_W'(i))
        wr_sel[i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= cfg.cfg_we && !wr_ok;
  end

  assign cfg.cfg_err = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_V)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[g]),
      .clr     (sync_clr),
      .wr      (wr_sel[g]),
      .wr_div  (cfg.cfg_div),
      .wr_mode (cfg.cfg_mode),
      .tick    (tick[g]),
      .wave    (wave[g])
    );
  end

endmodule

// File: doc/tick_gen_bank.md
TICK_GEN_BANK -- requirements
Module: tick_gen_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick channels (1..16).
REQ-002 Parameter CNT_W, default 32: width of each divisor and counter.
REQ-003 Parameter DEF_DIV, default 100000000: divisor loaded into every channel at reset (1 Hz from the 100 MHz clk).
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 ch_en  in  NUM_CH  per-channel count enable.
REQ-007 sync_clr  in  1  one-cycle strobe that phase-aligns all channels.
REQ-008 cfg_we  in  1  divisor/mode write strobe.
REQ-009 cfg_ch  in  clog2(NUM_CH), minimum 1  target channel of the write.
REQ-010 cfg_div  in  CNT_W  new divisor.
REQ-011 cfg_mode  in  1  new mode: 0 = PULSE, 1 = SQUARE.
REQ-012 tick  out  NUM_CH  one-cycle pulse per channel period.
REQ-013 wave  out  NUM_CH  per-channel mode-dependent level output.
REQ-014 cfg_err  out  1  one-cycle pulse flagging a rejected write.

Function
REQ-015 Each channel SHALL hold an active divisor D, a shadow divisor S with shadow mode, an active mode, a counter cnt, and registered tick and wave.
REQ-016 When enabled, cnt SHALL increment by 1 per clk; at cnt == D-1, cnt SHALL wrap to 0 and tick SHALL be 1 in the following cycle; otherwise tick SHALL be 0.
REQ-017 With D programmed, tick SHALL recur every D cycles; D = 1 SHALL give tick = 1 every cycle.
REQ-018 PULSE mode: wave SHALL equal tick.
REQ-019 SQUARE mode: wave SHALL toggle on every wrap, giving period 2*D at 50% duty.
REQ-020 ch_en = 0 SHALL freeze cnt and wave and force tick to 0; re-enabling SHALL resume from the frozen cnt.
REQ-021 A write with cfg_div != 0 and cfg_ch < NUM_CH SHALL load S and the shadow mode of channel cfg_ch; no other channel SHALL change.
REQ-022 S and the shadow mode SHALL become active at the channel's next wrap, so no period is truncated.
REQ-023 If a write coincides with a wrap of the same channel, the written value SHALL become active at that wrap.
REQ-024 While ch_en = 0, a written value SHALL become active in the cycle after the write.
REQ-025 A write with cfg_div == 0 or cfg_ch >= NUM_CH SHALL be ignored and SHALL pulse cfg_err high in the cycle after the write.
REQ-026 sync_clr SHALL, in one cycle, set every cnt to 0, wave to 0 and tick to 0, and copy every shadow into active, regardless of ch_en.
REQ-027 A write in the same cycle as sync_clr SHALL be captured and SHALL be active immediately after the clear.
REQ-028 A mode change SHALL set wave to 0 when it takes effect.
REQ-029 Counter arithmetic SHALL be CNT_W-bit unsigned; cnt SHALL never exceed D-1.

Reset
REQ-030 rst SHALL asynchronously set every cnt to 0, every D and S to DEF_DIV, every mode to PULSE, and tick, wave and cfg_err to 0.
REQ-031 Reset asserted mid-period SHALL abort the period; after release, the first tick SHALL occur on the DEF_DIV-th rising edge.
REQ-032 No output SHALL glitch or pulse during reset assertion.

Structure
REQ-033 Package tick_gen_pkg SHALL hold the mode encoding (PULSE/SQUARE) and the default-divisor constants for 2 Hz, 1 Hz, 4 Hz and 400 Hz (50000000, 100000000, 25000000, 250000).
REQ-034 One sub-module, tick_chan, SHALL implement a single channel; tick_gen_bank SHALL instantiate it NUM_CH times and decode cfg_ch and cfg_err.

Verification
REQ-035 Reset, set DEF_DIV=5 and all ch_en=1 -> tick on edges 5, 10, 15; wave equals tick on all channels.
REQ-036 Write ch1 div=3 mode=SQUARE at cnt=1 of a D=5 period -> current period completes at 5; then tick every 3 cycles and wave toggles with period 6.
REQ-037 Write cfg_div=0, or cfg_ch=NUM_CH -> cfg_err high for exactly 1 cycle; no channel's D, S or mode changes.
REQ-038 Channels running at D=4 and D=7, then sync_clr -> both cnt=0 and wave=0 next cycle; ticks 4 and 7 cycles later respectively.
REQ-039 ch_en[0] dropped for 10 cycles at cnt=2 with D=5 -> no tick during the gap; first tick 3 cycles after re-enable.
REQ-040 rst asserted asynchronously mid-period -> all outputs 0 immediately; after release, first tick at DEF_DIV; D=1 gives continuous tick.
